// File: rtl/signed_sub_with_saturation_pipe.sv
// signed_sub_with_saturation_pipe
//   Two-stage pipelined signed subtractor: res = a - b, clamped to the
//   representable WIDTH-bit signed range instead of wrapping.
//
//   Stage 1 : WIDTH+1-bit difference of the sign-extended operands, plus sign of a.
//   Stage 2 : overflow detect and clamp, registered result and flag.
//
// Ports
//   clk      rising-edge clock
//   rst_n    synchronous active-low reset
//   arg_vld  a/b valid this cycle (no backpressure)
//   a, b     signed minuend / subtrahend
//   res_vld  res/res_ovf valid (fixed latency 2)
//   res      saturated difference; holds its value while res_vld=0
//   res_ovf  result was clamped
//   sat_cnt  count of emitted clamped results, saturating at all-ones
//
// Build option
//   SIGNED_SUB_SAT_CNT_EN : when defined, sat_cnt is a live counter;
//                           otherwise it is tied to 0 and no counter exists.
module signed_sub_with_saturation_pipe #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             arg_vld,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             res_vld,
  output logic [WIDTH-1:0] res,
  output logic             res_ovf,
  output logic [CNT_W-1:0] sat_cnt
);

  localparam int STAGES = 2;
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef struct packed {
    logic [WIDTH:0] diff;
    logic           a_sign;
  } s1_t;

  logic [STAGES:1]  vld_pipe;
  s1_t              s1_q;
  logic             s1_ovf;
  logic [WIDTH-1:0] s1_sat;

  // Stage valids; a reset flushes everything in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) vld_pipe <= '0;
    else        vld_pipe <= {vld_pipe[STAGES-1:1], arg_vld};
  end

  // One extra bit keeps the true difference exact, including b = min negative.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= '0;
    end else if (arg_vld) begin
      s1_q.diff   <= {a[WIDTH-1], a} - {b[WIDTH-1], b};
      s1_q.a_sign <= a[WIDTH-1];
    end
  end

  // Top two bits disagree exactly when the difference does not fit in WIDTH
  // bits; on overflow the true result has the sign of a.
  always_comb begin
    s1_ovf = s1_q.diff[WIDTH] ^ s1_q.diff[WIDTH-1];
    s1_sat = s1_q.diff[WIDTH-1:0];
    if (s1_ovf) s1_sat = s1_q.a_sign ? MIN_NEG : MAX_POS;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res     <= '0;
      res_ovf <= 1'b0;
    end else if (vld_pipe[1]) begin
      res     <= s1_sat;
      res_ovf <= s1_ovf;
    end
  end

  assign res_vld = vld_pipe[STAGES];

`ifdef SIGNED_SUB_SAT_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Counts on the same edge that emits a clamped result; sticks at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n)                                 cnt_q <= '0;
    else if (vld_pipe[1] && s1_ovf && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
  end

  assign sat_cnt = cnt_q;
`else
  assign sat_cnt = '0;
`endif

endmodule

// File: tb/tb_signed_sub_with_saturation_pipe.sv
// Bench for signed_sub_with_saturation_pipe (WIDTH=4, CNT_W=2).
// Expected results come from an integer reference model and are queued when
// arguments are driven; a negedge monitor pops and compares on res_vld and
// tracks the expected saturation count. Scenario tasks add cycle-exact checks.
module tb_signed_sub_with_saturation_pipe;
  localparam int W    = 4;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct {
    logic [W-1:0] res;
    logic         ovf;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          arg_vld = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          res_vld;
  logic [W-1:0]  res;
  logic          res_ovf;
  logic [CW-1:0] sat_cnt;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   cnt_model = 0;
  bit   mon_en = 1'b0;

  signed_sub_with_saturation_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .arg_vld (arg_vld),
    .a       (a),
    .b       (b),
    .res_vld (res_vld),
    .res     (res),
    .res_ovf (res_ovf),
    .sat_cnt (sat_cnt)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(int x, int y);
    exp_t e;
    int   d;
    int   c;
    int   hi;
    int   lo;
    hi = (1 << (W - 1)) - 1;
    lo = -(1 << (W - 1));
    d  = x - y;
    c  = (d > hi) ? hi : (d < lo) ? lo : d;
    e.res = c[W-1:0];
    e.ovf = (c != d);
    return e;
  endfunction

  task automatic drive(input int x, input int y);
    arg_vld = 1'b1;
    a = x[W-1:0];
    b = y[W-1:0];
    exp_q.push_back(model(x, y));
  endtask

  task automatic idle();
    arg_vld = 1'b0;
    a = 4'($urandom_range(0, 15));
    b = 4'($urandom_range(0, 15));
  endtask

  // Scoreboard monitor: order and value of every emitted result, plus sat_cnt.
  always @(negedge clk) begin
    if (mon_en) begin
      if (res_vld) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_res got res=%0d ovf=%0b, none expected", $signed(res), res_ovf);
        end else begin
          mon_e = exp_q.pop_front();
          if ({res, res_ovf} !== {mon_e.res, mon_e.ovf}) begin
            failures++;
            $display("FAIL sb_res got res=%0d ovf=%0b want res=%0d ovf=%0b",
                     $signed(res), res_ovf, $signed(mon_e.res), mon_e.ovf);
          end
`ifdef SIGNED_SUB_SAT_CNT_EN
          if (mon_e.ovf && cnt_model < CMAX) cnt_model++;
`endif
        end
      end
      checks++;
      if (sat_cnt !== cnt_model[CW-1:0]) begin
        failures++;
        $display("FAIL sb_sat_cnt got %0d want %0d", sat_cnt, cnt_model);
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({res_vld, res, res_ovf, sat_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_state got vld=%b res=%b ovf=%b cnt=%b want all 0", res_vld, res, res_ovf, sat_cnt);
    end
    rst_n = 1'b1;
    cnt_model = 0;
    mon_en = 1'b1;
  endtask

  task automatic test_basic();
    @(posedge clk); #1; drive(3, 2);
    @(posedge clk); #1; idle();
    checks++;
    if (res_vld !== 1'b0) begin failures++; $display("FAIL basic_n1_vld got %b want 0", res_vld); end
    @(posedge clk); #1;
    checks++;
    if ({res_vld, res, res_ovf} !== {1'b1, 4'd1, 1'b0}) begin
      failures++;
      $display("FAIL basic_n2 got vld=%b res=%0d ovf=%b want 1/1/0", res_vld, $signed(res), res_ovf);
    end
    @(posedge clk); #1;
    checks++;
    if (res_vld !== 1'b0) begin failures++; $display("FAIL basic_n3_vld got %b want 0", res_vld); end
  endtask

  task automatic test_pos_ovf();
    @(posedge clk); #1; drive(7, -1);
    @(posedge clk); #1; drive(0, -8);
    @(posedge clk); #1; drive(-1, -8);
    checks++;
    if ({res, res_ovf} !== {4'd7, 1'b1}) begin
      failures++; $display("FAIL pos_ovf_7_m1 got res=%0d ovf=%b want 7/1", $signed(res), res_ovf);
    end
    @(posedge clk); #1; idle();
    checks++;
    if ({res, res_ovf} !== {4'd7, 1'b1}) begin
      failures++; $display("FAIL pos_ovf_0_m8 got res=%0d ovf=%b want 7/1", $signed(res), res_ovf);
    end
    @(posedge clk); #1;
    checks++;
    if ({res, res_ovf} !== {4'd7, 1'b0}) begin
      failures++; $display("FAIL sub_m1_m8 got res=%0d ovf=%b want 7/0", $signed(res), res_ovf);
    end
  endtask

  task automatic test_neg_ovf();
    @(posedge clk); #1; drive(-8, 1);
    @(posedge clk); #1; drive(-8, -8);
    @(posedge clk); #1; idle();
    checks++;
    if ({res, res_ovf} !== {4'b1000, 1'b1}) begin
      failures++; $display("FAIL neg_ovf_m8_1 got res=%b ovf=%b want 1000/1", res, res_ovf);
    end
    @(posedge clk); #1;
    checks++;
    if ({res, res_ovf} !== {4'd0, 1'b0}) begin
      failures++; $display("FAIL equal_m8_m8 got res=%b ovf=%b want 0000/0", res, res_ovf);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int xs[5] = '{1, -1, 6, -4, 2};
    int ys[5] = '{1, 7, -3, 4, -5};
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (i < 5) drive(xs[i], ys[i]);
      else       idle();
      checks++;
      if (res_vld !== ((i >= 2 && i <= 6) ? 1'b1 : 1'b0)) begin
        failures++; $display("FAIL stream_vld cycle=%0d got %b", i, res_vld);
      end
    end
    checks++;
    if (res !== 4'd7) begin failures++; $display("FAIL stream_hold got res=%0d want 7", $signed(res)); end
  endtask

  task automatic test_reset_midflight();
    @(posedge clk); #1; drive(7, -1);
    @(posedge clk); #1; idle(); rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    exp_q.delete();
    cnt_model = 0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({res_vld, res, res_ovf, sat_cnt} !== '0) begin
        failures++;
        $display("FAIL midflight_reset cycle=%0d got vld=%b res=%b ovf=%b cnt=%0d want all 0",
                 i, res_vld, res, res_ovf, sat_cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sat_cnt();
    int emitted;
    int want;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      if (i < 5) drive(7, -1);
      else       idle();
      emitted = (i >= 2) ? ((i - 1 > 5) ? 5 : i - 1) : 0;
`ifdef SIGNED_SUB_SAT_CNT_EN
      want = (emitted > CMAX) ? CMAX : emitted;
`else
      want = 0;
`endif
      checks++;
      if (sat_cnt !== want[CW-1:0]) begin
        failures++; $display("FAIL sat_cnt_step cycle=%0d got %0d want %0d", i, sat_cnt, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pos_ovf();
    test_neg_ovf();
    test_back_to_back();
    test_reset_midflight();
    test_sat_cnt();
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL lost_results got %0d pending want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
